// File: rtl/sega_joy_pkg.sv
// Shared constants, pin layout and small helpers for the DB9 Sega pad reader.
package sega_joy_pkg;

  localparam int unsigned PIN_W  = 6;
  localparam int unsigned WORD_W = 12;
  localparam int unsigned DIR_W  = 4;

  // Scan step numbers within one frame; everything from ST_IDLE upwards is idle.
  localparam int unsigned ST_SEL_LO0     = 0;
  localparam int unsigned ST_SEL_HI0     = 1;
  localparam int unsigned ST_SAMPLE_DPAD = 2;
  localparam int unsigned ST_SAMPLE_SA   = 3;
  localparam int unsigned ST_SEL_LO2     = 4;
  localparam int unsigned ST_SIX_CHK     = 5;
  localparam int unsigned ST_SAMPLE_XYZ  = 6;
  localparam int unsigned ST_IDLE        = 7;

  // Bit positions in the 12-bit button word {M,X,Y,Z,S,A,C,B,R,L,D,U}.
  localparam int unsigned JB_U = 0;
  localparam int unsigned JB_D = 1;
  localparam int unsigned JB_L = 2;
  localparam int unsigned JB_R = 3;
  localparam int unsigned JB_B = 4;
  localparam int unsigned JB_C = 5;
  localparam int unsigned JB_A = 6;
  localparam int unsigned JB_S = 7;
  localparam int unsigned JB_Z = 8;
  localparam int unsigned JB_Y = 9;
  localparam int unsigned JB_X = 10;
  localparam int unsigned JB_M = 11;

  localparam logic [WORD_W-1:0] RELEASED = 12'hFFF;

  // Raw DB9 pin bundle as presented on joy*_i.
  typedef struct packed {
    logic p9;
    logic p6;
    logic right;
    logic left;
    logic down;
    logic up;
  } pad_pins_t;

  // Direction nibble {R,L,D,U}; on a 6-button pad these pins carry {M,X,Y,Z} in the
  // high phase after the third low phase.
  function automatic logic [DIR_W-1:0] pad_dirs(input pad_pins_t p);
    return {p.right, p.left, p.down, p.up};
  endfunction

  // Select level driven after the tick of a given step.
  function automatic logic sel_after_step(input int unsigned step);
    logic lvl;
    lvl = 1'b1;
    case (step)
      ST_SEL_LO0, ST_SAMPLE_DPAD, ST_SEL_LO2, ST_SAMPLE_XYZ: lvl = 1'b0;
      ST_SEL_HI0, ST_SAMPLE_SA, ST_SIX_CHK, ST_IDLE:         lvl = 1'b1;
      default:                                               lvl = 1'b1;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/sega_pad_decode.sv
// Per-pad input synchroniser, 6-button detection and button word register.
module sega_pad_decode
  import sega_joy_pkg::*;
#(
  parameter int unsigned STEP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic [PIN_W-1:0]  pins_i,
  output logic [WORD_W-1:0] word_o,
  output logic              six_o
);

  logic [PIN_W-1:0]  sync1_q, sync1_d;
  logic [PIN_W-1:0]  sync2_q, sync2_d;
  logic              six_flag_q, six_flag_d;
  logic              six_q, six_d;
  logic [WORD_W-1:0] word_q, word_d;
  pad_pins_t         pins_c;

  assign pins_c = pad_pins_t'(sync2_q);

  // Next-state: synchroniser shift plus step-specific sampling on the scan tick.
  always_comb begin
    sync1_d    = pins_i;
    sync2_d    = sync1_q;
    six_flag_d = six_flag_q;
    six_d      = six_q;
    word_d     = word_q;
    if (tick_i) begin
      case (step_i)
        STEP_W'(ST_SAMPLE_DPAD): begin
          word_d[JB_C] = pins_c.p9;
          word_d[JB_B] = pins_c.p6;
          word_d[JB_R] = pins_c.right;
          word_d[JB_L] = pins_c.left;
          word_d[JB_D] = pins_c.down;
          word_d[JB_U] = pins_c.up;
          six_flag_d   = 1'b0;
        end
        STEP_W'(ST_SAMPLE_SA): begin
          // L and R both low only happens on a Mega Drive pad in the low phase.
          if (!pins_c.right && !pins_c.left) begin
            word_d[JB_S] = pins_c.p9;
            word_d[JB_A] = pins_c.p6;
          end else begin
            word_d[JB_S] = 1'b1;
            word_d[JB_A] = 1'b1;
          end
        end
        STEP_W'(ST_SIX_CHK): begin
          // Third low phase: a 6-button pad pulls all four directions low.
          if (pad_dirs(pins_c) == '0) begin
            six_flag_d = 1'b1;
          end
        end
        STEP_W'(ST_SAMPLE_XYZ): begin
          if (six_flag_q) begin
            word_d[JB_M] = pins_c.right;
            word_d[JB_X] = pins_c.left;
            word_d[JB_Y] = pins_c.down;
            word_d[JB_Z] = pins_c.up;
          end else begin
            word_d[JB_M] = 1'b1;
            word_d[JB_X] = 1'b1;
            word_d[JB_Y] = 1'b1;
            word_d[JB_Z] = 1'b1;
          end
          six_d = six_flag_q;
        end
        default: begin
        end
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      six_flag_q <= 1'b0;
      six_q      <= 1'b0;
      word_q     <= RELEASED;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      six_flag_q <= six_flag_d;
      six_q      <= six_d;
      word_q     <= word_d;
    end
  end

  assign word_o = word_q;
  assign six_o  = six_q;

endmodule

// File: rtl/sega_joy_reader.sv
// Two-pad DB9 Sega reader: scan timing, shared select line and frame strobe.
module sega_joy_reader
  import sega_joy_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1536,
  parameter int unsigned STEPS    = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PIN_W-1:0]  joy1_i,
  input  logic [PIN_W-1:0]  joy2_i,
  output logic              p7_o,
  output logic [WORD_W-1:0] joy1_o,
  output logic [WORD_W-1:0] joy2_o,
  output logic              six1_o,
  output logic              six2_o,
  output logic              frame_o
);

  localparam int unsigned PRE_W  = $clog2(TICK_DIV);
  localparam int unsigned STEP_W = $clog2(STEPS);

  logic [PRE_W-1:0]  prescaler_q, prescaler_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              p7_q, p7_d;
  logic              frame_q, frame_d;
  logic              tick_c;

  assign tick_c = (prescaler_q == PRE_W'(TICK_DIV - 1));

  // Next-state: prescaler, step counter, select level and frame strobe.
  always_comb begin
    prescaler_d = prescaler_q + PRE_W'(1);
    step_d      = step_q;
    p7_d        = p7_q;
    frame_d     = 1'b0;
    if (tick_c) begin
      prescaler_d = '0;
      step_d      = (step_q == STEP_W'(STEPS - 1)) ? '0 : step_q + STEP_W'(1);
      p7_d        = sel_after_step(32'(step_q));
      frame_d     = (step_q == STEP_W'(ST_SAMPLE_XYZ));
    end
  end

  // Timing registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler_q <= '0;
      step_q      <= '0;
      p7_q        <= 1'b1;
      frame_q     <= 1'b0;
    end else begin
      prescaler_q <= prescaler_d;
      step_q      <= step_d;
      p7_q        <= p7_d;
      frame_q     <= frame_d;
    end
  end

  sega_pad_decode #(
    .STEP_W (STEP_W)
  ) u_pad1 (
    .clk    (clk),
    .reset  (reset),
    .tick_i (tick_c),
    .step_i (step_q),
    .pins_i (joy1_i),
    .word_o (joy1_o),
    .six_o  (six1_o)
  );

  sega_pad_decode #(
    .STEP_W (STEP_W)
  ) u_pad2 (
    .clk    (clk),
    .reset  (reset),
    .tick_i (tick_c),
    .step_i (step_q),
    .pins_i (joy2_i),
    .word_o (joy2_o),
    .six_o  (six2_o)
  );

  assign p7_o    = p7_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_sega_joy_reader.sv
// Bench for sega_joy_reader with behavioural Sega pad models on both ports.
module tb_sega_joy_reader;

  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned STEPS    = 16;
  localparam int unsigned PERIOD   = TICK_DIV * STEPS;

  localparam int PAD_NONE = 0;
  localparam int PAD_SMS  = 1;
  localparam int PAD_MD3  = 2;
  localparam int PAD_MD6  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  joy1_i, joy2_i;
  logic        p7_o;
  logic [11:0] joy1_o, joy2_o;
  logic        six1_o, six2_o, frame_o;

  int          checks = 0;
  int          errors = 0;

  // Pad configuration: kind plus active-high pressed mask in word bit order.
  int          type1 = PAD_NONE;
  int          type2 = PAD_NONE;
  logic [11:0] btn1 = '0;
  logic [11:0] btn2 = '0;

  // 6-button pad state: select falling edges since the pad's idle timeout.
  int          sel_falls = 0;
  int          hi_time = 0;
  logic        p7_prev = 1'b1;
  longint      cyc = 0;
  longint      last_frame = 0;
  bit          have_last = 0;

  sega_joy_reader #(
    .TICK_DIV (TICK_DIV),
    .STEPS    (STEPS)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .joy1_i  (joy1_i),
    .joy2_i  (joy2_i),
    .p7_o    (p7_o),
    .joy1_o  (joy1_o),
    .joy2_o  (joy2_o),
    .six1_o  (six1_o),
    .six2_o  (six2_o),
    .frame_o (frame_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pad-side select edge counter with a long-idle reset, as in real 6-button pads.
  always @(negedge clk) begin
    if (p7_prev && !p7_o) sel_falls = sel_falls + 1;
    if (p7_o) begin
      hi_time = hi_time + 1;
      if (hi_time >= 16) sel_falls = 0;
    end else begin
      hi_time = 0;
    end
    p7_prev = p7_o;
  end

  // Pins {p9,p6,right,left,down,up} driven by a pad of the given kind.
  function automatic logic [5:0] pad_pins(input int kind, input logic [11:0] b,
                                          input logic sel, input int falls);
    logic [11:0] n;
    logic [5:0]  low_std;
    n       = ~b;
    low_std = {n[7], n[6], 2'b00, n[1], n[0]};
    case (kind)
      PAD_SMS: return n[5:0];
      PAD_MD3: return sel ? n[5:0] : low_std;
      PAD_MD6: begin
        if (sel) return (falls == 3) ? {n[5], n[4], n[11:8]} : n[5:0];
        if (falls == 3) return {n[7], n[6], 4'h0};
        if (falls == 4) return {n[7], n[6], 4'hF};
        return low_std;
      end
      default: return 6'h3F;
    endcase
  endfunction

  always_comb joy1_i = pad_pins(type1, btn1, p7_o, sel_falls);
  always_comb joy2_i = pad_pins(type2, btn2, p7_o, sel_falls);

  // Expected word: buttons the pad type can report, active-low.
  function automatic logic [11:0] exp_word(input int kind, input logic [11:0] b);
    logic [11:0] mask;
    case (kind)
      PAD_SMS: mask = 12'h03F;
      PAD_MD3: mask = 12'h0FF;
      PAD_MD6: mask = 12'hFFF;
      default: mask = 12'h000;
    endcase
    return ~(b & mask);
  endfunction

  // Random buttons without physically opposed directions.
  function automatic logic [11:0] rand_btn();
    logic [11:0] b;
    b = 12'($urandom);
    if (b[0] && b[1]) b[1] = 1'b0;
    if (b[2] && b[3]) b[3] = 1'b0;
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Bounded wait for frame_o, sampled on the falling edge; also checks the frame period.
  task automatic wait_frame(output bit seen);
    seen = 0;
    for (int i = 0; i < 3 * int'(PERIOD); i++) begin
      @(negedge clk);
      if (frame_o) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: no frame_o within %0d clks", 3 * PERIOD);
    end else begin
      if (have_last) check("frame_period", 32'(cyc - last_frame), PERIOD);
      last_frame = cyc;
      have_last  = 1;
    end
  endtask

  task automatic frame_check(input string tag, input logic [11:0] e1, input logic [11:0] e2,
                             input logic s1, input logic s2);
    bit seen;
    wait_frame(seen);
    if (seen) begin
      check({tag, "_joy1"}, 32'(joy1_o), 32'(e1));
      check({tag, "_joy2"}, 32'(joy2_o), 32'(e2));
      check({tag, "_six1"}, 32'(six1_o), 32'(s1));
      check({tag, "_six2"}, 32'(six2_o), 32'(s2));
    end
  endtask

  typedef struct {
    int          t1;
    logic [11:0] b1;
    int          t2;
    logic [11:0] b2;
    logic [11:0] e1;
    logic [11:0] e2;
    logic        s1;
    logic        s2;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int first;

    vecs[0] = '{PAD_MD3,  12'h041, PAD_NONE, 12'h000, 12'hFBE, 12'hFFF, 1'b0, 1'b0};
    vecs[1] = '{PAD_NONE, 12'h000, PAD_MD6,  12'h120, 12'hFFF, 12'hEDF, 1'b0, 1'b1};
    vecs[2] = '{PAD_SMS,  12'h010, PAD_NONE, 12'h000, 12'hFEF, 12'hFFF, 1'b0, 1'b0};
    vecs[3] = '{PAD_NONE, 12'h000, PAD_NONE, 12'h000, 12'hFFF, 12'hFFF, 1'b0, 1'b0};
    vecs[4] = '{PAD_MD6,  12'h000, PAD_MD3,  12'h080, 12'hFFF, 12'hF7F, 1'b1, 1'b0};
    vecs[5] = '{PAD_SMS,  12'h0C0, PAD_MD6,  12'h800, 12'hFFF, 12'h7FF, 1'b0, 1'b1};

    // Reset held for three clocks.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_p7", 32'(p7_o), 32'd1);
    check("rst_joy1", 32'(joy1_o), 32'hFFF);
    check("rst_joy2", 32'(joy2_o), 32'hFFF);
    check("rst_six", 32'({six1_o, six2_o}), 32'd0);
    check("rst_frame", 32'(frame_o), 32'd0);
    reset = 1'b0;

    // First tick on the fourth clock after release drops the select line.
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 3) check("pre_tick_p7", 32'(p7_o), 32'd1);
      if (k == 4) check("first_tick_p7", 32'(p7_o), 32'd0);
    end

    frame_check("first", 12'hFFF, 12'hFFF, 1'b0, 1'b0);

    // Directed vectors; pads are swapped right after a frame strobe.
    for (int r = 0; r < 6; r++) begin
      type1 = vecs[r].t1;
      btn1  = vecs[r].b1;
      type2 = vecs[r].t2;
      btn2  = vecs[r].b2;
      frame_check($sformatf("vec%0d", r), vecs[r].e1, vecs[r].e2, vecs[r].s1, vecs[r].s2);
    end

    // Randomised pads and buttons against the reporting model.
    for (int r = 0; r < 24; r++) begin
      type1 = int'($urandom_range(0, 3));
      type2 = int'($urandom_range(0, 3));
      btn1  = rand_btn();
      btn2  = rand_btn();
      frame_check($sformatf("rnd%0d", r), exp_word(type1, btn1), exp_word(type2, btn2),
                  type1 == PAD_MD6, type2 == PAD_MD6);
    end

    // Reset during step 4 of a frame.
    type1 = PAD_MD3;
    btn1  = 12'h040;
    type2 = PAD_NONE;
    btn2  = '0;
    frame_check("pre_rst", 12'hFBF, 12'hFFF, 1'b0, 1'b0);
    repeat (53) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_p7", 32'(p7_o), 32'd1);
    check("mid_rst_joy1", 32'(joy1_o), 32'hFFF);
    check("mid_rst_six", 32'({six1_o, six2_o}), 32'd0);
    check("mid_rst_frame", 32'(frame_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    first = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (frame_o) begin
        first = n;
        break;
      end
    end
    check("post_rst_frame_delay", 32'(first), 32'd28);
    check("post_rst_joy1", 32'(joy1_o), 32'hFBF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
